// File: rtl/fp_pkg.sv
// Shared sizes, default colours and write-FSM state type for the fingerprint frame buffer.
package fp_pkg;
    localparam int FP_IMG_W = 256;
    localparam int FP_IMG_H = 256;

    localparam logic [15:0] FP_FG_COLOR = 16'h0000;
    localparam logic [15:0] FP_BG_COLOR = 16'hFFFF;
    localparam logic [15:0] FP_BD_COLOR = 16'h001F;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        PENDING
    } fp_wr_state_t;
endpackage

// File: rtl/fp_frame_buffer_if.sv
// Row-load and LCD pixel bus of the frame buffer; slave is the buffer, master is its environment.
interface fp_frame_buffer_if;
    import fp_pkg::*;

    logic                ram_clk;
    logic [7:0]          ram_add;
    logic [FP_IMG_W-1:0] ram_data;
    logic [9:0]          lcd_x;
    logic [9:0]          lcd_y;
    logic                lcd_de;
    logic                lcd_frame_start;
    logic [15:0]         pix_rgb;
    logic                pix_de;
    logic                frame_valid;
    logic [8:0]          rows_loaded;
    logic                overrun;

    modport master (
        output ram_clk, ram_add, ram_data, lcd_x, lcd_y, lcd_de, lcd_frame_start,
        input  pix_rgb, pix_de, frame_valid, rows_loaded, overrun
    );

    modport slave (
        input  ram_clk, ram_add, ram_data, lcd_x, lcd_y, lcd_de, lcd_frame_start,
        output pix_rgb, pix_de, frame_valid, rows_loaded, overrun
    );
endinterface

// File: rtl/fp_row_ram.sv
// One image bank: 256 rows x 256 bits, one write port, registered read port.
module fp_row_ram
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [7:0]          waddr,
    input  logic [FP_IMG_W-1:0] wdata,
    input  logic [7:0]          raddr,
    output logic [FP_IMG_W-1:0] rdata
);
    logic [FP_IMG_W-1:0] mem [FP_IMG_H];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/fp_frame_buffer.sv
// Fingerprint frame store feeding the LCD with a centred 256x256 image, 2-clk pixel latency.
// Define FPBUF_DOUBLE_BUF_EN for two banks swapped on lcd_frame_start; default is one live bank.
//
//  state   | meaning
//  IDLE    | waiting for the first row of a new frame
//  CAPTURE | rows arriving; row 255 ends the frame
//  PENDING | full frame in back bank, waiting for lcd_frame_start to swap
module fp_frame_buffer
    import fp_pkg::*;
#(
    parameter int unsigned  WIN_X    = 112,
    parameter int unsigned  WIN_Y    = 8,
    parameter logic [15:0]  FG_COLOR = FP_FG_COLOR,
    parameter logic [15:0]  BG_COLOR = FP_BG_COLOR,
    parameter logic [15:0]  BD_COLOR = FP_BD_COLOR
) (
    input logic              clk,
    input logic              rst_n,
    fp_frame_buffer_if.slave bus
);
    fp_wr_state_t        state_q, state_d;
    logic                ram_clk_d, armed_q;
    logic                wr_ev, wr_en;
    logic [8:0]          rows_q, rows_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic [9:0]          dx, dy;
    logic                in_win, in_win_s1, de_s1;
    logic [7:0]          col_s1;
    logic [FP_IMG_W-1:0] row_rd;
    logic [15:0]         pix_rgb_q;
    logic                pix_de_q;

    // armed_q requires ram_clk to be seen low after reset, so a strobe held high through reset is ignored.
    assign wr_ev = bus.ram_clk & ~ram_clk_d & armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ram_clk_d <= 1'b0;
            armed_q   <= 1'b0;
            rows_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ram_clk_d <= bus.ram_clk;
            armed_q   <= armed_q | ~bus.ram_clk;
            rows_q    <= rows_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_ev) begin
                    wr_en   = 1'b1;
                    rows_d  = 9'd1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (wr_ev) begin
                    wr_en = 1'b1;
                    if (bus.ram_add == 8'd0) begin
                        rows_d = 9'd1;
                    end else if (rows_q != 9'd256) begin
                        rows_d = rows_q + 9'd1;
                    end
                    if (bus.ram_add == 8'hFF) begin
`ifdef FPBUF_DOUBLE_BUF_EN
                        state_d = PENDING;
`else
                        state_d = IDLE;
                        valid_d = 1'b1;
`endif
                    end
                end
            end
            PENDING: begin
                if (wr_ev) begin
                    ovr_d = 1'b1;
                end
                if (bus.lcd_frame_start) begin
                    valid_d = 1'b1;
                    rows_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Unsigned wrap makes coordinates left of / above the window read as outside.
    assign dx     = bus.lcd_x - 10'(WIN_X);
    assign dy     = bus.lcd_y - 10'(WIN_Y);
    assign in_win = (dx < 10'd256) && (dy < 10'd256);

`ifdef FPBUF_DOUBLE_BUF_EN
    logic                front_q, front_s1;
    logic [FP_IMG_W-1:0] rd0, rd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q  <= 1'b0;
            front_s1 <= 1'b0;
        end else begin
            if (state_q == PENDING && bus.lcd_frame_start) begin
                front_q <= ~front_q;
            end
            front_s1 <= front_q;
        end
    end

    fp_row_ram u_bank0 (
        .clk   (clk),
        .we    (wr_en & front_q),
        .waddr (bus.ram_add),
        .wdata (bus.ram_data),
        .raddr (dy[7:0]),
        .rdata (rd0)
    );

    fp_row_ram u_bank1 (
        .clk   (clk),
        .we    (wr_en & ~front_q),
        .waddr (bus.ram_add),
        .wdata (bus.ram_data),
        .raddr (dy[7:0]),
        .rdata (rd1)
    );

    assign row_rd = front_s1 ? rd1 : rd0;
`else
    fp_row_ram u_bank0 (
        .clk   (clk),
        .we    (wr_en),
        .waddr (bus.ram_add),
        .wdata (bus.ram_data),
        .raddr (dy[7:0]),
        .rdata (row_rd)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_win_s1 <= 1'b0;
            col_s1    <= '0;
            de_s1     <= 1'b0;
            pix_rgb_q <= BD_COLOR;
            pix_de_q  <= 1'b0;
        end else begin
            in_win_s1 <= in_win;
            col_s1    <= dx[7:0];
            de_s1     <= bus.lcd_de;
            pix_de_q  <= de_s1;
            if (!valid_q || !in_win_s1) begin
                pix_rgb_q <= BD_COLOR;
            end else if (row_rd[col_s1]) begin
                pix_rgb_q <= FG_COLOR;
            end else begin
                pix_rgb_q <= BG_COLOR;
            end
        end
    end

    assign bus.pix_rgb     = pix_rgb_q;
    assign bus.pix_de      = pix_de_q;
    assign bus.frame_valid = valid_q;
    assign bus.rows_loaded = rows_q;
    assign bus.overrun     = ovr_q;
endmodule
